// File: rtl/heartbeat_pattern.sv
`default_nettype none
// ============================================================================
// Module   : heartbeat_pattern
// Brief    : multi-channel status-LED pattern generator with frame-aligned loads
// Revision : 1.0
// ============================================================================
module heartbeat_pattern #(
  parameter int unsigned CLOCK_HZ        = 16000000,
  parameter int unsigned STEP_HZ         = 16,
  parameter int unsigned STEPS           = 16,
  parameter int unsigned CHANNELS        = 4,
  parameter logic [31:0] DEFAULT_PATTERN = 32'h0000_0005
) (
  input  logic                                             clock_i,
  input  logic                                             reset_ni,
  input  logic                                             enable_i,
  input  logic                                             load_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel_i,
  input  logic [1:0]                                       mode_i,
  input  logic [STEPS-1:0]                                 pattern_i,
  output logic [CHANNELS-1:0]                              pending_o,
  output logic [$clog2(STEPS)-1:0]                         step_o,
  output logic                                             frame_o,
  output logic [CHANNELS-1:0]                              pulse_o
);

  localparam int unsigned c_div  = CLOCK_HZ / STEP_HZ;
  localparam int unsigned c_pw   = (c_div > 1) ? $clog2(c_div) : 1;
  localparam int unsigned c_sw   = $clog2(STEPS);
  localparam int unsigned c_selw = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] c_mode_off = 2'b00;
  localparam logic [1:0] c_mode_on  = 2'b01;
  localparam logic [1:0] c_mode_pat = 2'b10;

  localparam logic [STEPS-1:0] c_default = DEFAULT_PATTERN[STEPS-1:0];

  logic [c_pw-1:0] r_presc;
  logic [c_sw-1:0] r_step;
  logic            r_frame;
  logic            w_tick;
  logic            w_wrap;
  logic            w_commit;

  assign w_tick   = enable_i && (r_presc == c_pw'(c_div - 1));
  assign w_wrap   = w_tick && (r_step == c_sw'(STEPS - 1));
  // While disabled there is no frame to protect, so shadows go live every cycle.
  assign w_commit = w_wrap || !enable_i;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_presc <= '0;
      r_step  <= '0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_wrap;
      if (!enable_i) begin
        r_presc <= '0;
        r_step  <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_step  <= w_wrap ? '0 : r_step + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign step_o  = r_step;
  assign frame_o = r_frame;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    localparam logic [c_selw-1:0] c_idx = c_selw'(c);

    logic [1:0]       r_act_mode;
    logic [1:0]       r_sh_mode;
    logic [STEPS-1:0] r_act_pat;
    logic [STEPS-1:0] r_sh_pat;
    logic             r_pend;
    logic             r_pulse;
    logic             w_hit;
    logic             w_bit;
    logic             w_level;

    // Out-of-range selects match no channel and are dropped here.
    assign w_hit = load_i && (sel_i == c_idx);
    assign w_bit = r_act_pat[r_step];

    always_comb begin
      w_level = 1'b0;
      case (r_act_mode)
        c_mode_off: w_level = 1'b0;
        c_mode_on:  w_level = 1'b1;
        c_mode_pat: w_level = w_bit;
        default:    w_level = ~w_bit;
      endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
        r_act_mode <= c_mode_pat;
        r_act_pat  <= c_default;
        r_sh_mode  <= c_mode_pat;
        r_sh_pat   <= c_default;
        r_pend     <= 1'b0;
        r_pulse    <= 1'b0;
      end else begin
        r_pulse <= enable_i && w_level;
        if (w_commit && r_pend) begin
          r_act_mode <= r_sh_mode;
          r_act_pat  <= r_sh_pat;
        end
        // A load coinciding with a commit refills the shadow and keeps it pending.
        if (w_hit) begin
          r_sh_mode <= mode_i;
          r_sh_pat  <= pattern_i;
          r_pend    <= 1'b1;
        end else if (w_commit) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign pending_o[c] = r_pend;
    assign pulse_o[c]   = r_pulse;
  end

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_pattern.sv
`default_nettype none
// Bench for heartbeat_pattern: directed scenarios plus random loads/enables,
// checked every cycle against a count-based model of the pattern frame.
module tb_heartbeat_pattern;

  localparam int CH    = 4;
  localparam int ST    = 16;
  localparam int DIVV  = 16;
  localparam int FRAME = DIVV * ST;

  logic        clock_i = 1'b0;
  logic        reset_ni;
  logic        enable_i;
  logic        load_i;
  logic [1:0]  sel_i;
  logic [1:0]  mode_i;
  logic [15:0] pattern_i;
  logic [3:0]  pending_o;
  logic [3:0]  step_o;
  logic        frame_o;
  logic [3:0]  pulse_o;

  logic        load3;
  logic [1:0]  sel3;
  logic [2:0]  pend3;
  logic [3:0]  step3;
  logic        frame3;
  logic [2:0]  pulse3;

  always #5 clock_i = ~clock_i;

  heartbeat_pattern #(
    .CLOCK_HZ(160), .STEP_HZ(10), .STEPS(16), .CHANNELS(4), .DEFAULT_PATTERN(32'h0005)
  ) u_dut (
    .clock_i(clock_i), .reset_ni(reset_ni), .enable_i(enable_i), .load_i(load_i),
    .sel_i(sel_i), .mode_i(mode_i), .pattern_i(pattern_i), .pending_o(pending_o),
    .step_o(step_o), .frame_o(frame_o), .pulse_o(pulse_o)
  );

  // Three channels so that a 2-bit select can address a missing channel.
  heartbeat_pattern #(
    .CLOCK_HZ(160), .STEP_HZ(10), .STEPS(16), .CHANNELS(3), .DEFAULT_PATTERN(32'h0005)
  ) u_dut3 (
    .clock_i(clock_i), .reset_ni(reset_ni), .enable_i(enable_i), .load_i(load3),
    .sel_i(sel3), .mode_i(mode_i), .pattern_i(pattern_i), .pending_o(pend3),
    .step_o(step3), .frame_o(frame3), .pulse_o(pulse3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: enabled-cycle count gives the timebase by plain division.
  int          en_cnt;
  logic [1:0]  m_mode [CH];
  logic [15:0] m_pat  [CH];
  logic [1:0]  s_mode [CH];
  logic [15:0] s_pat  [CH];
  logic [3:0]  m_pend;
  logic [3:0]  e_pulse;
  logic        e_frame;

  function automatic logic level(input logic [1:0] md, input logic [15:0] p, input int s);
    case (md)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return p[s];
      default: return ~p[s];
    endcase
  endfunction

  task automatic model_reset();
    en_cnt = 0;
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 2'b10; m_pat[c] = 16'h0005;
      s_mode[c] = 2'b10; s_pat[c] = 16'h0005;
    end
    m_pend = '0; e_pulse = '0; e_frame = 1'b0;
  endtask

  task automatic model_edge();
    int  s;
    bit  wrap;
    s    = (en_cnt / DIVV) % ST;
    wrap = enable_i && (en_cnt % FRAME == FRAME - 1);
    for (int c = 0; c < CH; c++)
      e_pulse[c] = enable_i ? level(m_mode[c], m_pat[c], s) : 1'b0;
    e_frame = wrap;
    if (wrap || !enable_i)
      for (int c = 0; c < CH; c++)
        if (m_pend[c]) begin
          m_mode[c] = s_mode[c]; m_pat[c] = s_pat[c]; m_pend[c] = 1'b0;
        end
    if (load_i) begin
      s_mode[sel_i] = mode_i; s_pat[sel_i] = pattern_i; m_pend[sel_i] = 1'b1;
    end
    en_cnt = enable_i ? en_cnt + 1 : 0;
  endtask

  task automatic cycle();
    @(posedge clock_i);
    if (!reset_ni) model_reset();
    else           model_edge();
    #1;
    check_eq("step",    step_o,    (en_cnt / DIVV) % ST);
    check_eq("frame",   frame_o,   e_frame);
    check_eq("pulse",   pulse_o,   e_pulse);
    check_eq("pending", pending_o, m_pend);
    load_i = 1'b0;
    load3  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the next edge is the given cycle-within-frame.
  task automatic run_until(input int phase);
    int n;
    n = 0;
    while ((en_cnt % FRAME) != phase && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    check_eq("wait_phase", en_cnt % FRAME, phase);
  endtask

  task automatic do_load(input logic [1:0] s, input logic [1:0] m, input logic [15:0] p);
    load_i = 1'b1; sel_i = s; mode_i = m; pattern_i = p;
  endtask

  initial begin
    reset_ni = 1'b0; enable_i = 1'b1; load_i = 1'b0; sel_i = '0; mode_i = '0;
    pattern_i = '0; load3 = 1'b0; sel3 = '0;
    model_reset();
    #2;
    check_eq("rst_step",    step_o,    0);
    check_eq("rst_frame",   frame_o,   0);
    check_eq("rst_pulse",   pulse_o,   0);
    check_eq("rst_pending", pending_o, 0);
    run(3);
    reset_ni = 1'b1;

    // Default double blink over two frames.
    run(2 * FRAME);

    // Channel 1 forced on, loaded mid-frame at step 5.
    run_until(5 * DIVV);
    do_load(2'd1, 2'b01, 16'h0000);
    cycle();
    run(FRAME);

    // Last load before commit wins.
    run_until(2 * DIVV);
    do_load(2'd2, 2'b10, 16'hFFFF);
    run(7);
    do_load(2'd2, 2'b10, 16'h8000);
    cycle();
    run(2 * FRAME);

    // Load landing exactly on the wrap edge stays pending for a frame.
    run_until(4 * DIVV);
    do_load(2'd3, 2'b01, 16'h0000);
    cycle();
    run_until(FRAME - 1);
    do_load(2'd3, 2'b11, 16'h00F0);
    cycle();
    check_eq("wrap_load_pending", pending_o[3], 1'b1);
    run(2 * FRAME);

    // Disable mid-frame commits the pending load immediately.
    run_until(3 * DIVV);
    do_load(2'd0, 2'b01, 16'h0000);
    cycle();
    run_until(7 * DIVV);
    enable_i = 1'b0;
    cycle();
    check_eq("dis_step",  step_o,  0);
    check_eq("dis_pulse", pulse_o, 0);
    do_load(2'd0, 2'b11, 16'h1234);
    run(4);
    enable_i = 1'b1;
    run(3 * DIVV);

    // Asynchronous reset mid-frame drops pending shadows.
    run_until(9 * DIVV + 3);
    do_load(2'd1, 2'b00, 16'h0000);
    cycle();
    reset_ni = 1'b0;
    #1;
    model_reset();
    check_eq("arst_step",    step_o,    0);
    check_eq("arst_pulse",   pulse_o,   0);
    check_eq("arst_pending", pending_o, 0);
    run(2);
    reset_ni = 1'b1;

    // Out-of-range select on the three-channel instance.
    load3 = 1'b1; sel3 = 2'd3; mode_i = 2'b01; pattern_i = 16'hFFFF;
    cycle();
    check_eq("oor_pending", pend3, 3'b000);
    load3 = 1'b1; sel3 = 2'd2; mode_i = 2'b00;
    cycle();
    check_eq("inr_pending", pend3, 3'b100);
    check_eq("dut3_step",   step3, (en_cnt / DIVV) % ST);
    check_eq("dut3_frame",  frame3, e_frame);
    check_eq("dut3_pulse",  pulse3, e_pulse[2:0]);
    run(FRAME);

    // Random loads and enable drops.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0)
        do_load(2'($urandom_range(3)), 2'($urandom_range(3)), 16'($urandom));
      if (enable_i && $urandom_range(299) == 0) enable_i = 1'b0;
      else if (!enable_i && $urandom_range(7) == 0) enable_i = 1'b1;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
